// File: rtl/regfile_sb.sv
// regfile_sb: XLEN x NREG register file, two combinational read ports, an ALU and a
// multiplier write port, and a per-register busy scoreboard for long-latency results.

module regfile_sb_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wa,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb,
  input  logic [XLEN-1:0] wb_data,
  input  logic            rsv,
  output logic [XLEN-1:0] q,
  output logic            bsy
);
  // ALU data beats multiplier data; a new reservation beats a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      bsy <= 1'b0;
    end else begin
      if (wa)      q <= wa_data;
      else if (wb) q <= wb_data;
      if (rsv)     bsy <= 1'b1;
      else if (wb) bsy <= 1'b0;
    end
  end
endmodule

module regfile_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] q,
  input  logic            bsy,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rwdata,
  input  logic            mwe,
  input  logic [AW-1:0]   mrd,
  input  logic [XLEN-1:0] mwdata,
  input  logic            res_valid,
  input  logic [AW-1:0]   res_rd,
  output logic [XLEN-1:0] rv,
  output logic            busy
);
  logic zero, hit_a, hit_b, hit_r;

  assign zero  = (rs == '0);
  assign hit_a = (BYPASS != 0) && we  && (rd  == rs);
  assign hit_b = (BYPASS != 0) && mwe && (mrd == rs);
  assign hit_r = res_valid && (res_rd == rs);

  always_comb begin
    rv   = q;
    busy = bsy;
    if (zero) begin
      rv   = '0;
      busy = 1'b0;
    end else begin
      if (hit_a)      rv = rwdata;
      else if (hit_b) rv = mwdata;
      if (hit_b && !hit_r) busy = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rwdata,
  input  logic            mwe,
  input  logic [AW-1:0]   mrd,
  input  logic [XLEN-1:0] mwdata,
  input  logic            res_valid,
  input  logic [AW-1:0]   res_rd,
  output logic [XLEN-1:0] xlast,
  output logic            busy_any
);
  localparam int NUM_LANES = 2;

  logic [NREG-1:0][XLEN-1:0]      q_all;
  logic [NREG-1:0]                bsy_all;
  logic [NUM_LANES-1:0][AW-1:0]   rs_l;
  logic [NUM_LANES-1:0][XLEN-1:0] rv_l;
  logic [NUM_LANES-1:0]           busy_l;

  // Register 0 has no storage at all, so nothing can ever make it nonzero.
  assign q_all[0]   = '0;
  assign bsy_all[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    regfile_sb_entry #(.XLEN(XLEN)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .wa      (we && (rd == AW'(i))),
      .wa_data (rwdata),
      .wb      (mwe && (mrd == AW'(i))),
      .wb_data (mwdata),
      .rsv     (res_valid && (res_rd == AW'(i))),
      .q       (q_all[i]),
      .bsy     (bsy_all[i])
    );
  end

  assign rs_l = {rs2, rs1};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_rd
    regfile_sb_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .rs        (rs_l[l]),
      .q         (q_all[rs_l[l]]),
      .bsy       (bsy_all[rs_l[l]]),
      .we        (we),
      .rd        (rd),
      .rwdata    (rwdata),
      .mwe       (mwe),
      .mrd       (mrd),
      .mwdata    (mwdata),
      .res_valid (res_valid),
      .res_rd    (res_rd),
      .rv        (rv_l[l]),
      .busy      (busy_l[l])
    );
  end

  assign rv1      = rv_l[0];
  assign rv2      = rv_l[1];
  assign busy1    = busy_l[0];
  assign busy2    = busy_l[1];
  assign xlast    = q_all[NREG-1];
  assign busy_any = |bsy_all;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypassing 32x32, non-bypassing 32x32 and a 64-bit 16-entry instance.
module tb_regfile_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs1, rs2, rd, mrd, res_rd;
  logic        we, mwe, res_valid;
  logic [31:0] rwdata, mwdata;
  logic [31:0] rv1, rv2, xlast, rv1z, rv2z, xlastz;
  logic        busy1, busy2, busy_any, busy1z, busy2z, busy_anyz;

  logic [3:0]  rs1w, rs2w, rdw, mrdw, res_rdw;
  logic        wew, mwew, res_validw;
  logic [63:0] rwdataw, mwdataw, rv1w, rv2w, xlastw;
  logic        busy1w, busy2w, busy_anyw;

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2), .busy1(busy1), .busy2(busy2),
    .we(we), .rd(rd), .rwdata(rwdata), .mwe(mwe), .mrd(mrd), .mwdata(mwdata),
    .res_valid(res_valid), .res_rd(res_rd), .xlast(xlast), .busy_any(busy_any));

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_z (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rv1(rv1z), .rv2(rv2z), .busy1(busy1z), .busy2(busy2z),
    .we(we), .rd(rd), .rwdata(rwdata), .mwe(mwe), .mrd(mrd), .mwdata(mwdata),
    .res_valid(res_valid), .res_rd(res_rd), .xlast(xlastz), .busy_any(busy_anyz));

  regfile_sb #(.XLEN(64), .NREG(16), .BYPASS(1)) dut_w (
    .clk(clk), .rst(rst), .rs1(rs1w), .rs2(rs2w), .rv1(rv1w), .rv2(rv2w), .busy1(busy1w), .busy2(busy2w),
    .we(wew), .rd(rdw), .rwdata(rwdataw), .mwe(mwew), .mrd(mrdw), .mwdata(mwdataw),
    .res_valid(res_validw), .res_rd(res_rdw), .xlast(xlastw), .busy_any(busy_anyw));

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [63:0] e;
  logic [31:0] mreg[32];
  logic        mbusy[32];

  task automatic idle();
    rst = 1'b0; rs1 = '0; rs2 = '0; we = 1'b0; rd = '0; rwdata = '0;
    mwe = 1'b0; mrd = '0; mwdata = '0; res_valid = 1'b0; res_rd = '0;
    rs1w = '0; rs2w = '0; wew = 1'b0; rdw = '0; rwdataw = '0;
    mwew = 1'b0; mrdw = '0; mwdataw = '0; res_validw = 1'b0; res_rdw = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); rst = 1'b1;
    we = 1'b1; rd = 5'd31; rwdata = 32'h1111_2222; res_valid = 1'b1; res_rd = 5'd3;
    wew = 1'b1; rdw = 4'd15; rwdataw = 64'h5555;
    @(negedge clk); idle(); rs1 = 5'd5; rs2 = 5'd31; rs1w = 4'd5; rs2w = 4'd15;
    repeat (7) sb.push_back(64'h0);
    #1;
    e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL rst_rv1 got=%h exp=%h", rv1, e[31:0]); end
    e = sb.pop_front(); checks++; if (rv2 !== e[31:0]) begin failures++; $display("FAIL rst_rv2 got=%h exp=%h", rv2, e[31:0]); end
    e = sb.pop_front(); checks++; if (xlast !== e[31:0]) begin failures++; $display("FAIL rst_xlast got=%h exp=%h", xlast, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy_any !== e[0]) begin failures++; $display("FAIL rst_busy_any got=%b exp=%b", busy_any, e[0]); end
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL rst_rv1z got=%h exp=%h", rv1z, e[31:0]); end
    e = sb.pop_front(); checks++; if (xlastw !== e) begin failures++; $display("FAIL rst_xlastw got=%h exp=%h", xlastw, e); end
    e = sb.pop_front(); checks++; if (busy_anyw !== e[0]) begin failures++; $display("FAIL rst_busy_anyw got=%b exp=%b", busy_anyw, e[0]); end
  endtask

  task automatic test_write_zero();
    @(negedge clk); idle(); we = 1'b1; rd = 5'd0; rwdata = 32'hDEAD_BEEF; rs1 = 5'd0;
    sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL wr0_byp got=%h exp=%h", rv1, e[31:0]); end
    @(negedge clk); idle(); rs1 = 5'd0;
    sb.push_back(64'h0); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL wr0_rv1 got=%h exp=%h", rv1, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy1 !== e[0]) begin failures++; $display("FAIL wr0_busy1 got=%b exp=%b", busy1, e[0]); end
    @(negedge clk); idle(); we = 1'b1; rd = 5'd7; rwdata = 32'h1234_5678; rs1 = 5'd7;
    sb.push_back(64'h1234_5678); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL wr7_byp got=%h exp=%h", rv1, e[31:0]); end
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL wr7_nobyp got=%h exp=%h", rv1z, e[31:0]); end
    @(negedge clk); idle(); rs1 = 5'd7;
    sb.push_back(64'h1234_5678); sb.push_back(64'h1234_5678); #1;
    e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL wr7_rv1 got=%h exp=%h", rv1, e[31:0]); end
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL wr7_rv1z got=%h exp=%h", rv1z, e[31:0]); end
  endtask

  task automatic test_reserve();
    @(negedge clk); idle(); res_valid = 1'b1; res_rd = 5'd9; rs1 = 5'd9;
    sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (busy1 !== e[0]) begin failures++; $display("FAIL rsv_same got=%b exp=%b", busy1, e[0]); end
    @(negedge clk); idle(); rs1 = 5'd9;
    sb.push_back(64'h1); sb.push_back(64'h1); sb.push_back(64'h1); #1;
    e = sb.pop_front(); checks++; if (busy1 !== e[0]) begin failures++; $display("FAIL rsv_busy1 got=%b exp=%b", busy1, e[0]); end
    e = sb.pop_front(); checks++; if (busy_any !== e[0]) begin failures++; $display("FAIL rsv_busy_any got=%b exp=%b", busy_any, e[0]); end
    e = sb.pop_front(); checks++; if (busy1z !== e[0]) begin failures++; $display("FAIL rsv_busy1z got=%b exp=%b", busy1z, e[0]); end
    repeat (2) begin @(negedge clk); idle(); end
    @(negedge clk); idle(); mwe = 1'b1; mrd = 5'd9; mwdata = 32'hCAFE_0001; rs1 = 5'd9;
    sb.push_back(64'h0); sb.push_back(64'hCAFE_0001); sb.push_back(64'h1); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (busy1 !== e[0]) begin failures++; $display("FAIL cpl_busy1 got=%b exp=%b", busy1, e[0]); end
    e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL cpl_rv1 got=%h exp=%h", rv1, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy1z !== e[0]) begin failures++; $display("FAIL cpl_busy1z got=%b exp=%b", busy1z, e[0]); end
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL cpl_rv1z got=%h exp=%h", rv1z, e[31:0]); end
    @(negedge clk); idle(); rs1 = 5'd9;
    sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'hCAFE_0001); #1;
    e = sb.pop_front(); checks++; if (busy_any !== e[0]) begin failures++; $display("FAIL cpl_busy_any got=%b exp=%b", busy_any, e[0]); end
    e = sb.pop_front(); checks++; if (busy_anyz !== e[0]) begin failures++; $display("FAIL cpl_busy_anyz got=%b exp=%b", busy_anyz, e[0]); end
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL cpl_rv1z_next got=%h exp=%h", rv1z, e[31:0]); end
  endtask

  task automatic test_collide();
    @(negedge clk); idle(); res_valid = 1'b1; res_rd = 5'd4;
    @(negedge clk); idle(); we = 1'b1; rd = 5'd4; rwdata = 32'hA; mwe = 1'b1; mrd = 5'd4; mwdata = 32'hB;
    rs1 = 5'd4; rs2 = 5'd4;
    sb.push_back(64'hA); sb.push_back(64'h0); sb.push_back(64'h1); #1;
    e = sb.pop_front(); checks++; if (rv2 !== e[31:0]) begin failures++; $display("FAIL ab_prio got=%h exp=%h", rv2, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy1 !== e[0]) begin failures++; $display("FAIL ab_busy1 got=%b exp=%b", busy1, e[0]); end
    e = sb.pop_front(); checks++; if (busy2z !== e[0]) begin failures++; $display("FAIL ab_busy2z got=%b exp=%b", busy2z, e[0]); end
    @(negedge clk); idle(); rs1 = 5'd4;
    sb.push_back(64'hA); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL ab_reg4 got=%h exp=%h", rv1z, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy1z !== e[0]) begin failures++; $display("FAIL ab_busy4 got=%b exp=%b", busy1z, e[0]); end
  endtask

  task automatic test_res_vs_complete();
    @(negedge clk); idle(); res_valid = 1'b1; res_rd = 5'd12;
    @(negedge clk); idle(); res_valid = 1'b1; res_rd = 5'd12; mwe = 1'b1; mrd = 5'd12; mwdata = 32'h55; rs2 = 5'd12;
    sb.push_back(64'h1); sb.push_back(64'h55); #1;
    e = sb.pop_front(); checks++; if (busy2 !== e[0]) begin failures++; $display("FAIL rc_busy2 got=%b exp=%b", busy2, e[0]); end
    e = sb.pop_front(); checks++; if (rv2 !== e[31:0]) begin failures++; $display("FAIL rc_rv2 got=%h exp=%h", rv2, e[31:0]); end
    @(negedge clk); idle(); res_valid = 1'b1; res_rd = 5'd0; we = 1'b1; rd = 5'd0; rwdata = 32'hFFFF; rs2 = 5'd12;
    sb.push_back(64'h55); sb.push_back(64'h1); #1;
    e = sb.pop_front(); checks++; if (rv2z !== e[31:0]) begin failures++; $display("FAIL rc_reg12 got=%h exp=%h", rv2z, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy2z !== e[0]) begin failures++; $display("FAIL rc_busy12 got=%b exp=%b", busy2z, e[0]); end
    @(negedge clk); idle(); rs1 = 5'd0;
    sb.push_back(64'h0); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (busy1z !== e[0]) begin failures++; $display("FAIL r0_busy got=%b exp=%b", busy1z, e[0]); end
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL r0_val got=%h exp=%h", rv1z, e[31:0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle(); res_valid = 1'b1; res_rd = 5'd3;
    @(negedge clk); idle(); res_valid = 1'b1; res_rd = 5'd20; we = 1'b1; rd = 5'd31; rwdata = 32'h77;
    sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (xlast !== e[31:0]) begin failures++; $display("FAIL xl_nobyp got=%h exp=%h", xlast, e[31:0]); end
    @(negedge clk); idle(); rs1 = 5'd20;
    sb.push_back(64'h77); sb.push_back(64'h1); #1;
    e = sb.pop_front(); checks++; if (xlast !== e[31:0]) begin failures++; $display("FAIL xl_val got=%h exp=%h", xlast, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy1 !== e[0]) begin failures++; $display("FAIL rm_busy20 got=%b exp=%b", busy1, e[0]); end
    @(negedge clk); idle(); rst = 1'b1; we = 1'b1; rd = 5'd31; rwdata = 32'h99;
    mwe = 1'b1; mrd = 5'd3; mwdata = 32'h5; res_valid = 1'b1; res_rd = 5'd7;
    @(negedge clk); idle(); rs1 = 5'd3;
    sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (xlast !== e[31:0]) begin failures++; $display("FAIL rm_xlast got=%h exp=%h", xlast, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy_any !== e[0]) begin failures++; $display("FAIL rm_busy_any got=%b exp=%b", busy_any, e[0]); end
    e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL rm_reg3 got=%h exp=%h", rv1, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy_anyz !== e[0]) begin failures++; $display("FAIL rm_busy_anyz got=%b exp=%b", busy_anyz, e[0]); end
    @(negedge clk); idle(); mwe = 1'b1; mrd = 5'd3; mwdata = 32'h33;
    @(negedge clk); idle(); rs1 = 5'd3;
    sb.push_back(64'h33); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL rm_post got=%h exp=%h", rv1z, e[31:0]); end
    e = sb.pop_front(); checks++; if (busy1z !== e[0]) begin failures++; $display("FAIL rm_post_busy got=%b exp=%b", busy1z, e[0]); end
  endtask

  task automatic test_wide();
    @(negedge clk); idle(); wew = 1'b1; rdw = 4'd0; rwdataw = 64'hDEAD_BEEF_DEAD_BEEF; rs1w = 4'd0;
    sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (rv1w !== e) begin failures++; $display("FAIL w_wr0 got=%h exp=%h", rv1w, e); end
    @(negedge clk); idle(); wew = 1'b1; rdw = 4'd7; rwdataw = 64'h0123_4567_89AB_CDEF; rs1w = 4'd7;
    sb.push_back(64'h0123_4567_89AB_CDEF); #1;
    e = sb.pop_front(); checks++; if (rv1w !== e) begin failures++; $display("FAIL w_byp got=%h exp=%h", rv1w, e); end
    @(negedge clk); idle(); wew = 1'b1; rdw = 4'd15; rwdataw = 64'hF00D_0000_0000_BEEF; rs1w = 4'd7; rs2w = 4'd15;
    sb.push_back(64'h0123_4567_89AB_CDEF); sb.push_back(64'hF00D_0000_0000_BEEF); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (rv1w !== e) begin failures++; $display("FAIL w_reg7 got=%h exp=%h", rv1w, e); end
    e = sb.pop_front(); checks++; if (rv2w !== e) begin failures++; $display("FAIL w_byp15 got=%h exp=%h", rv2w, e); end
    e = sb.pop_front(); checks++; if (xlastw !== e) begin failures++; $display("FAIL w_xl_nobyp got=%h exp=%h", xlastw, e); end
    @(negedge clk); idle(); rs1w = 4'd0;
    sb.push_back(64'hF00D_0000_0000_BEEF); sb.push_back(64'h0); #1;
    e = sb.pop_front(); checks++; if (xlastw !== e) begin failures++; $display("FAIL w_xlast got=%h exp=%h", xlastw, e); end
    e = sb.pop_front(); checks++; if (rv1w !== e) begin failures++; $display("FAIL w_reg0 got=%h exp=%h", rv1w, e); end
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] m_rv(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && rd == a) return rwdata;
    if (mwe && mrd == a) return mwdata;
    return mreg[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (mwe && mrd == a && !(res_valid && res_rd == a)) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic test_back_to_back();
    logic any;
    @(negedge clk); idle(); rst = 1'b1;
    for (int i = 0; i < 32; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); idle();
      we = 1'($urandom_range(0, 1)); rd = pick(); rwdata = $urandom;
      mwe = 1'($urandom_range(0, 1)); mrd = pick(); mwdata = $urandom;
      res_valid = 1'($urandom_range(0, 1)); res_rd = pick();
      rs1 = pick(); rs2 = ($urandom_range(0, 3) == 0) ? rs1 : pick();
      any = 1'b0;
      for (int i = 0; i < 32; i++) any = any | mbusy[i];
      sb.push_back(64'(m_rv(rs1))); sb.push_back(64'(m_rv(rs2)));
      sb.push_back(64'(m_busy(rs1))); sb.push_back(64'(m_busy(rs2)));
      sb.push_back(64'(mreg[31])); sb.push_back(64'(any));
      sb.push_back(64'((rs1 == 0) ? 32'h0 : mreg[rs1])); sb.push_back(64'((rs2 == 0) ? 1'b0 : mbusy[rs2]));
      #1;
      e = sb.pop_front(); checks++; if (rv1 !== e[31:0]) begin failures++; $display("FAIL b2b_rv1 n=%0d got=%h exp=%h", n, rv1, e[31:0]); end
      e = sb.pop_front(); checks++; if (rv2 !== e[31:0]) begin failures++; $display("FAIL b2b_rv2 n=%0d got=%h exp=%h", n, rv2, e[31:0]); end
      e = sb.pop_front(); checks++; if (busy1 !== e[0]) begin failures++; $display("FAIL b2b_busy1 n=%0d got=%b exp=%b", n, busy1, e[0]); end
      e = sb.pop_front(); checks++; if (busy2 !== e[0]) begin failures++; $display("FAIL b2b_busy2 n=%0d got=%b exp=%b", n, busy2, e[0]); end
      e = sb.pop_front(); checks++; if (xlast !== e[31:0]) begin failures++; $display("FAIL b2b_xlast n=%0d got=%h exp=%h", n, xlast, e[31:0]); end
      e = sb.pop_front(); checks++; if (busy_any !== e[0]) begin failures++; $display("FAIL b2b_busy_any n=%0d got=%b exp=%b", n, busy_any, e[0]); end
      e = sb.pop_front(); checks++; if (rv1z !== e[31:0]) begin failures++; $display("FAIL b2b_rv1z n=%0d got=%h exp=%h", n, rv1z, e[31:0]); end
      e = sb.pop_front(); checks++; if (busy2z !== e[0]) begin failures++; $display("FAIL b2b_busy2z n=%0d got=%b exp=%b", n, busy2z, e[0]); end
      if (mwe && mrd != 0) begin mreg[mrd] = mwdata; mbusy[mrd] = 1'b0; end
      if (we && rd != 0) mreg[rd] = rwdata;
      if (res_valid && res_rd != 0) mbusy[res_rd] = 1'b1;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_zero();
    test_reserve();
    test_collide();
    test_res_vs_complete();
    test_reset_mid();
    test_wide();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of every register and data port, in bits.
REQ-002 Parameter NREG, default 32: number of registers; SHALL be a power of two, 4..64; AW = log2(NREG).
REQ-003 Parameter BYPASS, default 1: 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.
REQ-004 Port clk  in  1: single clock; all state updates on posedge clk.
REQ-005 Port rst  in  1: reset, synchronous and active-high.
REQ-006 Ports rs1, rs2  in  AW: read addresses.
REQ-007 Ports rv1, rv2  out  XLEN: combinational read data for rs1 and rs2.
REQ-008 Ports busy1, busy2  out  1: combinational scoreboard bit for rs1 and rs2.
REQ-009 Ports we, rd, rwdata  in  1/AW/XLEN: write port A, single-cycle ALU writeback.
REQ-010 Ports mwe, mrd, mwdata  in  1/AW/XLEN: write port B, multiplier writeback; also clears the busy bit of mrd.
REQ-011 Ports res_valid, res_rd  in  1/AW: reserve res_rd as pending long-latency destination (set busy).
REQ-012 Port xlast  out  XLEN: debug view of register NREG-1, stored value only, never bypassed.
REQ-013 Port busy_any  out  1: OR of all busy bits.

Function
REQ-014 Register 0 SHALL read as 0 on rv1/rv2 and busy1/busy2 = 0 for address 0, regardless of any write, reservation or bypass.
REQ-015 Writes and reservations addressed to register 0 SHALL be ignored; register 0 storage and busy bit stay 0.
REQ-016 Port A: when we=1 and rd!=0, reg[rd] <= rwdata at posedge clk.
REQ-017 Port B: when mwe=1 and mrd!=0, reg[mrd] <= mwdata and busy[mrd] <= 0 at posedge clk.
REQ-018 Same-cycle port A and port B write to the same nonzero register: port A data SHALL be stored; busy[mrd] still clears.
REQ-019 res_valid=1, res_rd!=0: busy[res_rd] <= 1 at posedge clk.
REQ-020 Same-cycle reservation and port B completion on the same register: reservation wins, busy stays 1; port B data is still stored.
REQ-021 Port A writes SHALL NOT alter busy bits; WAW stalls are the pipeline's responsibility.
REQ-022 Read latency: rv1/rv2/busy1/busy2 combinational from rs1/rs2 and current state; 0 cycles.
REQ-023 BYPASS=1: rv1 = rwdata if we and rd==rs1!=0; else mwdata if mwe and mrd==rs1!=0; else reg[rs1]; same rule for rv2; port A has priority.
REQ-024 BYPASS=1: busy1 SHALL read 0 when mwe=1 and mrd==rs1, unless res_valid=1 and res_rd==rs1 in the same cycle (same for busy2).
REQ-025 BYPASS=0: rv1/rv2/busy1/busy2 reflect stored state only; new data visible the cycle after the write.
REQ-026 Addresses are AW bits wide; no out-of-range access exists.

Reset
REQ-027 While rst=1 at posedge clk, all registers SHALL become 0 and all busy bits 0; writes and reservations that cycle SHALL be discarded.
REQ-028 After reset: rv1=rv2=xlast=0, busy1=busy2=busy_any=0.
REQ-029 Reset mid-operation (busy bits set, port B write pending) SHALL leave no busy bit set; a later mwe to that register SHALL store data normally.
REQ-030 Before the first reset, register contents are undefined except register 0; the bench SHALL reset first.

Verification
REQ-031 rst 1 cycle; rs1=5, rs2=31 -> rv1=0, rv2=0, xlast=0, busy_any=0.
REQ-032 we=1, rd=0, rwdata=0xDEADBEEF; next cycle rs1=0 -> rv1=0; we=1, rd=7, rwdata=0x12345678 with rs1=7 same cycle -> rv1=0x12345678 (BYPASS=1) or old value (BYPASS=0), 0x12345678 next cycle in both.
REQ-033 res_valid=1, res_rd=9; next cycle rs1=9 -> busy1=1, busy_any=1; 3 cycles later mwe=1, mrd=9, mwdata=0xCAFE0001 -> same cycle busy1=0, rv1=0xCAFE0001 (BYPASS=1); next cycle busy_any=0.
REQ-034 we=1, rd=4, rwdata=0xA; mwe=1, mrd=4, mwdata=0xB same cycle with busy[4]=1 -> reg[4]=0xA, busy[4]=0 next cycle.
REQ-035 busy[12]=1; res_valid=1, res_rd=12 and mwe=1, mrd=12, mwdata=0x55 same cycle -> reg[12]=0x55, busy[12]=1 next cycle.
REQ-036 Set busy[3], busy[20], write reg[31]=0x77; assert rst with we=1, rd=31 -> next cycle xlast=0, busy_any=0; repeat REQ-032 with XLEN=64, NREG=16.
